// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access pipeline stage: data-memory access
// type codes, the write-back select code for loads, and the stage FSM state type.
package mem_pkg;

  localparam logic [2:0] DM_WORD   = 3'd0;
  localparam logic [2:0] DM_HALF   = 3'd1;
  localparam logic [2:0] DM_HALF_U = 3'd2;
  localparam logic [2:0] DM_BYTE   = 3'd3;
  localparam logic [2:0] DM_BYTE_U = 3'd4;

  localparam logic [2:0] WD_MEM = 3'd1;

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering for the data-memory bus: store byte enables and
// data replication, load lane selection with sign/zero extension.
// Optional feature: MISALIGN_TRAP_EN flags half/word accesses that straddle
// their natural alignment; without it the unused low address bits are ignored.
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  dmtype,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane steering and extension, selected by access type.
  always_comb begin
    byte_lane  = load_word[{addr_lo, 3'b000} +: 8];
    half_lane  = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    be         = 4'b1111;
    wdata      = store_data;
    load_data  = load_word;
    misaligned = 1'b0;
    case (dmtype)
      DM_BYTE, DM_BYTE_U: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = (dmtype == DM_BYTE) ? {{24{byte_lane[7]}}, byte_lane}
                                        : {24'b0, byte_lane};
      end
      DM_HALF, DM_HALF_U: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = (dmtype == DM_HALF) ? {{16{half_lane[15]}}, half_lane}
                                        : {16'b0, half_lane};
`ifdef MISALIGN_TRAP_EN
        misaligned = addr_lo[0];
`endif
      end
      default: begin
        // Word access (and unused codes) pass the full word through.
`ifdef MISALIGN_TRAP_EN
        misaligned = |addr_lo;
`endif
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage. Non-memory ops pass through in one cycle;
// loads/stores issue a request on the data-memory bus and stall the upstream
// pipeline until the memory acknowledges.
// Optional feature: MISALIGN_TRAP_EN completes misaligned half/word accesses in
// one cycle with misalign_out=1 instead of issuing them.
module mem_access_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] alures_in,
  input  logic [31:0] rs2_data_in,
  input  logic [4:0]  rd_in,
  input  logic [1:0]  MemWrite_in,
  input  logic [2:0]  DMType_in,
  input  logic [1:0]  RegWrite_in,
  input  logic [2:0]  WDSel_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        valid_out,
  output logic [31:0] PC_out,
  output logic [4:0]  rd_out,
  output logic [1:0]  RegWrite_out,
  output logic [2:0]  WDSel_out,
  output logic [31:0] alures_out,
  output logic [31:0] memdata_out,
  output logic        misalign_out
);

  state_t      state_q, state_d;
  logic        is_store, is_load, memop, align_mis, trap, mem_issue, ack_done, complete;
  logic [3:0]  align_be;
  logic [31:0] align_wdata, align_rdata;

  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;

  logic        valid_q;
  logic [31:0] pc_q, alures_q, memdata_q;
  logic [4:0]  rd_q;
  logic [1:0]  regwrite_q;
  logic [2:0]  wdsel_q;

  mem_align u_align (
    .addr_lo    (alures_in[1:0]),
    .dmtype     (DMType_in),
    .store_data (rs2_data_in),
    .load_word  (dmem_rdata),
    .be         (align_be),
    .wdata      (align_wdata),
    .load_data  (align_rdata),
    .misaligned (align_mis)
  );

  assign is_store  = |MemWrite_in;
  assign is_load   = (WDSel_in == WD_MEM);
  assign memop     = valid_in & (is_store | is_load);
  assign trap      = memop & align_mis;
  assign mem_issue = memop & ~align_mis;
  assign ack_done  = (state_q == StWait) & dmem_ack;
  // Upstream is held until the bus access finishes; released in the ack cycle.
  assign stall_out = mem_issue & ~ack_done;
  // Ops that reach MEM/WB at the coming edge.
  assign complete  = ack_done | ((state_q == StIdle) & valid_in & ~mem_issue);

  // Next-state logic: leave IDLE on an issued access, return on ack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (mem_issue) state_d = StWait;
      StWait:  if (dmem_ack)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Bus request registers: latched on issue, held stable for the whole wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if ((state_q == StIdle) && mem_issue) begin
      req_q   <= 1'b1;
      we_q    <= is_store;
      addr_q  <= {alures_in[31:2], 2'b00};
      wdata_q <= align_wdata;
      be_q    <= align_be;
    end else if (ack_done) begin
      req_q <= 1'b0;
      we_q  <= 1'b0;
      be_q  <= '0;
    end
  end

  // MEM/WB output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rd_q       <= '0;
      regwrite_q <= '0;
      wdsel_q    <= '0;
      alures_q   <= '0;
      memdata_q  <= '0;
    end else begin
      valid_q <= complete;
      if (complete) begin
        pc_q       <= PC_in;
        rd_q       <= rd_in;
        regwrite_q <= trap ? 2'b00 : RegWrite_in;
        wdsel_q    <= WDSel_in;
        alures_q   <= alures_in;
        memdata_q  <= (ack_done && !is_store) ? align_rdata : 32'b0;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;

  // Misalignment flag travels with the op it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           misalign_q <= 1'b0;
    else if (complete) misalign_q <= trap;
  end

  assign misalign_out = misalign_q;
`else
  assign misalign_out = 1'b0;
`endif

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;
  assign valid_out    = valid_q;
  assign PC_out       = pc_q;
  assign rd_out       = rd_q;
  assign RegWrite_out = regwrite_q;
  assign WDSel_out    = wdsel_q;
  assign alures_out   = alures_q;
  assign memdata_out  = memdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: the driver computes expected MEM/WB
// results and bus transactions from a byte-level memory model, a responder
// plays the data memory, and a monitor checks every valid_out.
module tb_mem_access_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] PC_in, alures_in, rs2_data_in;
  logic [4:0]  rd_in;
  logic [1:0]  MemWrite_in, RegWrite_in;
  logic [2:0]  DMType_in, WDSel_in;
  logic        stall_out, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        valid_out, misalign_out;
  logic [31:0] PC_out, alures_out, memdata_out;
  logic [4:0]  rd_out;
  logic [1:0]  RegWrite_out;
  logic [2:0]  WDSel_out;
  logic        resp_ack, stray_ack;

  assign dmem_ack = resp_ack | stray_ack;

  mem_access_stage dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .PC_in        (PC_in),
    .alures_in    (alures_in),
    .rs2_data_in  (rs2_data_in),
    .rd_in        (rd_in),
    .MemWrite_in  (MemWrite_in),
    .DMType_in    (DMType_in),
    .RegWrite_in  (RegWrite_in),
    .WDSel_in     (WDSel_in),
    .stall_out    (stall_out),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .valid_out    (valid_out),
    .PC_out       (PC_out),
    .rd_out       (rd_out),
    .RegWrite_out (RegWrite_out),
    .WDSel_out    (WDSel_out),
    .alures_out   (alures_out),
    .memdata_out  (memdata_out),
    .misalign_out (misalign_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [1:0]  rw;
    logic [2:0]  wd;
    logic [31:0] alu;
    logic [31:0] mdata;
    logic        mis;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          delay;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];

  int checks = 0;
  int errors = 0;

  // Memory contents seen by the responder and by the reference model.
  logic [31:0] ram     [bit [29:0]];
  logic [31:0] ref_mem [bit [29:0]];

  function automatic logic [31:0] fill_word(input bit [29:0] idx);
    return {idx[15:0], 2'b00, 14'h0} ^ (32'h9E37_79B1 * {2'b00, idx});
  endfunction

  function automatic logic [31:0] ram_rd(input bit [29:0] idx);
    return ram.exists(idx) ? ram[idx] : fill_word(idx);
  endfunction

  function automatic logic [31:0] ref_rd(input bit [29:0] idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : fill_word(idx);
  endfunction

  function automatic int width_of(input logic [2:0] dm);
    if (dm == DM_BYTE || dm == DM_BYTE_U) return 1;
    if (dm == DM_HALF || dm == DM_HALF_U) return 2;
    return 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one op, predict its result, and follow it until MEM/WB captures it.
  task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic [1:0] mw, input logic [2:0] dm,
                       input logic [1:0] rw, input logic [2:0] wd, input int delay);
    exp_t        e;
    bus_t        b;
    int          w, boff, exp_stall, cnt;
    logic        is_mem, mis;
    logic [31:0] word, lane;
    is_mem = (mw != 0) || (wd == WD_MEM);
    w      = width_of(dm);
    mis    = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = is_mem && ((w == 2 && alu[0]) || (w == 4 && alu[1:0] != 0));
`endif
    boff = (w == 1) ? int'(alu[1:0]) : (w == 2) ? int'(alu[1]) * 2 : 0;
    e = '{pc: pc, rd: rd, rw: mis ? 2'b00 : rw, wd: wd, alu: alu, mdata: 32'h0, mis: mis};
    if (is_mem && !mis) begin
      b.addr  = {alu[31:2], 2'b00};
      b.we    = (mw != 0);
      b.delay = delay;
      b.be    = 4'h0;
      b.wdata = 32'h0;
      word    = ref_rd(alu[31:2]);
      if (mw != 0) begin
        for (int i = 0; i < 4; i++) begin
          b.wdata[8*i +: 8] = rs2[8*(i % w) +: 8];
          if (i >= boff && i < boff + w) begin
            b.be[i] = 1'b1;
            word[8*i +: 8] = b.wdata[8*i +: 8];
          end
        end
        ref_mem[alu[31:2]] = word;
      end else begin
        lane = word >> (8 * boff);
        if (w == 1) begin
          e.mdata = {24'h0, lane[7:0]};
          if (dm == DM_BYTE && lane[7]) e.mdata = e.mdata | 32'hFFFF_FF00;
        end else if (w == 2) begin
          e.mdata = {16'h0, lane[15:0]};
          if (dm == DM_HALF && lane[15]) e.mdata = e.mdata | 32'hFFFF_0000;
        end else begin
          e.mdata = lane;
        end
      end
      bus_q.push_back(b);
    end
    exp_q.push_back(e);
    exp_stall = (is_mem && !mis) ? delay + 1 : 0;

    valid_in = 1'b1; PC_in = pc; alures_in = alu; rs2_data_in = rs2; rd_in = rd;
    MemWrite_in = mw; DMType_in = dm; RegWrite_in = rw; WDSel_in = wd;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!stall_out) break;
      if (cnt > 0) chk("valid_out low while waiting", valid_out, 1'b0);
      cnt++;
      @(posedge clk); #1;
    end
    chk("stall_out cycles", cnt, exp_stall);
    @(posedge clk); #1;
    chk("valid_out after capture", valid_out, 1'b1);
    valid_in = 1'b0;
  endtask

  task automatic bubble();
    valid_in = 1'b0; PC_in = $urandom; alures_in = $urandom; rs2_data_in = $urandom;
    MemWrite_in = 2'($urandom); WDSel_in = WD_MEM;
    @(negedge clk);
    chk("stall_out on bubble", stall_out, 1'b0);
    @(posedge clk); #1;
    chk("valid_out after bubble", valid_out, 1'b0);
  endtask

  // Data-memory responder: checks each request, then acks after the chosen delay.
  initial begin : responder
    bus_t        cur;
    logic        active;
    int          cnt;
    logic [31:0] word;
    resp_ack   = 1'b0;
    dmem_rdata = 32'h0;
    active     = 1'b0;
    cnt        = 0;
    cur        = '{addr: 0, we: 0, be: 0, wdata: 0, delay: 0};
    forever begin
      @(posedge clk); #1;
      resp_ack   = 1'b0;
      dmem_rdata = $urandom;
      if (active && !dmem_req) begin
        active = 1'b0;
      end else if (active) begin
        cnt++;
        chk("dmem_addr held", dmem_addr, cur.addr);
        chk("dmem_we held", dmem_we, cur.we);
      end else if (dmem_req) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected dmem_req: got addr %h, expected no request", dmem_addr);
        end else begin
          cur    = bus_q.pop_front();
          active = 1'b1;
          cnt    = 0;
          chk("dmem_addr", dmem_addr, cur.addr);
          chk("dmem_we", dmem_we, cur.we);
          if (cur.we) begin
            chk("dmem_be", dmem_be, cur.be);
            chk("dmem_wdata", dmem_wdata, cur.wdata);
          end
        end
      end
      if (active && cnt == cur.delay && cur.delay < 20) begin
        resp_ack = 1'b1;
        word     = ram_rd(cur.addr[31:2]);
        if (cur.we) begin
          for (int i = 0; i < 4; i++)
            if (cur.be[i]) word[8*i +: 8] = cur.wdata[8*i +: 8];
          ram[cur.addr[31:2]] = word;
        end
        dmem_rdata = word;
        active     = 1'b0;
      end
    end
  end

  // Monitor: every valid_out must match the oldest predicted result.
  always @(negedge clk) begin
    if (!rst && valid_out) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected valid_out: got pc %h, expected no output", PC_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("PC_out", PC_out, e.pc);
        chk("rd_out", rd_out, e.rd);
        chk("RegWrite_out", RegWrite_out, e.rw);
        chk("WDSel_out", WDSel_out, e.wd);
        chk("alures_out", alures_out, e.alu);
        chk("memdata_out", memdata_out, e.mdata);
        chk("misalign_out", misalign_out, e.mis);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int          kind;
    logic [2:0]  dm;
    logic [31:0] a;
    rst = 1'b1; stray_ack = 1'b0; valid_in = 1'b0;
    PC_in = '0; alures_in = '0; rs2_data_in = '0; rd_in = '0;
    MemWrite_in = '0; DMType_in = '0; RegWrite_in = '0; WDSel_in = '0;
    @(negedge clk);
    chk("reset valid_out", valid_out, 1'b0);
    chk("reset dmem_req", dmem_req, 1'b0);
    chk("reset dmem_be", dmem_be, 4'h0);
    chk("reset misalign_out", misalign_out, 1'b0);
    chk("reset PC_out", PC_out, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Load byte at 0x1003 from word 0x80FF_FFFF, acked in the first wait cycle.
    ram[30'h400] = 32'h80FF_FFFF;
    ref_mem[30'h400] = 32'h80FF_FFFF;
    issue(32'h100, 32'h1003, 32'h0, 5'd1, 2'd0, DM_BYTE, 2'd1, WD_MEM, 0);
    // Store half at 0x2002.
    issue(32'h104, 32'h2002, 32'h0000_BEEF, 5'd0, 2'd1, DM_HALF, 2'd0, 3'd0, 1);
    // Load word with a three-cycle ack delay.
    issue(32'h108, 32'h2000, 32'h0, 5'd2, 2'd0, DM_WORD, 2'd1, WD_MEM, 3);
    // ALU op directly followed by a memory op.
    issue(32'h10C, 32'h1234, 32'h0, 5'd5, 2'd0, DM_WORD, 2'd1, 3'd0, 0);
    issue(32'h110, 32'h1000, 32'h0, 5'd6, 2'd0, DM_HALF_U, 2'd1, WD_MEM, 2);
`ifdef MISALIGN_TRAP_EN
    issue(32'h114, 32'h3001, 32'h0, 5'd7, 2'd0, DM_WORD, 2'd1, WD_MEM, 0);
`endif
    bubble();

    // Reset in the middle of a wait, then a late ack: nothing may come out.
    bus_q.push_back('{addr: 32'h4000, we: 1'b0, be: 4'h0, wdata: 32'h0, delay: 30});
    valid_in = 1'b1; PC_in = 32'h200; alures_in = 32'h4000; rd_in = 5'd9;
    MemWrite_in = 2'd0; DMType_in = DM_WORD; RegWrite_in = 2'd1; WDSel_in = WD_MEM;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("dmem_req before reset", dmem_req, 1'b1);
    rst = 1'b1; valid_in = 1'b0;
    #1;
    chk("dmem_req on reset", dmem_req, 1'b0);
    chk("stall_out on reset", stall_out, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    stray_ack = 1'b1;
    @(posedge clk); #1;
    stray_ack = 1'b0;
    chk("valid_out after late ack", valid_out, 1'b0);
    chk("dmem_req after late ack", dmem_req, 1'b0);
    @(posedge clk); #1;

    // Random mix of ALU ops, loads, stores and bubbles in a small address window.
    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 3);
      dm   = 3'($urandom_range(0, 4));
      a    = 32'h0000_0100 + $urandom_range(0, 63);
      case (kind)
        0: issue($urandom, $urandom, $urandom, 5'($urandom), 2'd0, dm, 2'($urandom),
                 ($urandom_range(0, 1) != 0) ? 3'd2 : 3'd0, 0);
        1: issue($urandom, a, $urandom, 5'($urandom), 2'd0, dm, 2'($urandom), WD_MEM,
                 $urandom_range(0, 3));
        2: issue($urandom, a, $urandom, 5'($urandom), 2'($urandom_range(1, 3)), dm,
                 2'($urandom), 3'd0, $urandom_range(0, 3));
        default: bubble();
      endcase
    end

    repeat (4) @(posedge clk);
    #1;
    chk("outstanding results", exp_q.size(), 0);
    chk("outstanding bus requests", bus_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
